// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM state type and
// counter sizing helper.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Counter must hold 0..width inclusive.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/ready/done operation bus of the serial subtractor.
interface serial_subtractor_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    modport master (
        output start, a, b, bin,
        input  ready, busy, done, diff, bout, ovf
    );

    modport slave (
        input  start, a, b, bin,
        output ready, busy, done, diff, bout, ovf
    );
endinterface

// File: rtl/serial_subtractor_fs.sv
// Single-bit full subtractor cell: d = x - y - bi, with borrow-out bo.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);
    always_comb begin
        d  = x ^ y ^ bi;
        bo = (~x & y) | (~(x ^ y) & bi);
    end
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin LSB first through one full
// subtractor cell, one bit per clock, with registered results.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input logic                clk,
    input logic                rst,
    serial_subtractor_if.slave bus
);
    localparam int unsigned CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] work;
    logic [CW-1:0]    cnt;
    logic             brw;
    logic             a_msb;
    logic             b_msb;
    logic             fs_d;
    logic             fs_bo;
    logic [WIDTH-1:0] diff_r;
    logic             bout_r;
    logic             ovf_r;

    full_subtractor u_fs (
        .x  (a_sh[0]),
        .y  (b_sh[0]),
        .bi (brw),
        .d  (fs_d),
        .bo (fs_bo)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = SHIFT;
            SHIFT:   if (cnt == LAST) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh  <= '0;
            b_sh  <= '0;
            work  <= '0;
            cnt   <= '0;
            brw   <= 1'b0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
        end else if (state == IDLE && bus.start) begin
            a_sh  <= bus.a;
            b_sh  <= bus.b;
            brw   <= bus.bin;
            cnt   <= '0;
            a_msb <= bus.a[WIDTH-1];
            b_msb <= bus.b[WIDTH-1];
        end else if (state == SHIFT) begin
            work <= {fs_d, work[WIDTH-1:1]};
            brw  <= fs_bo;
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            cnt  <= cnt + CW'(1);
        end
    end

    // Results are taken straight from the cell on the final SHIFT edge so
    // they land in the output registers on the same edge that enters DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            diff_r <= '0;
            bout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else if (state == SHIFT && cnt == LAST) begin
            diff_r <= {fs_d, work[WIDTH-1:1]};
            bout_r <= fs_bo;
            ovf_r  <= (a_msb != b_msb) && (fs_d != a_msb);
        end
    end

    assign bus.ready = (state == IDLE);
    assign bus.busy  = (state == SHIFT);
    assign bus.done  = (state == DONE);
    assign bus.diff  = diff_r;
    assign bus.bout  = bout_r;
    assign bus.ovf   = ovf_r;

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial N-bit subtractor computing a − b − bin one bit per clock, LSB first, using a single full-subtractor cell and a registered borrow. It is the subtracting counterpart to the team's combinational adder blocks. It trades latency for area in arithmetic datapaths where a full-width subtractor is not justified. A start/ready/done handshake lets a controller issue one operation at a time.

## Interface

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..64.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request; sampled only while ready=1.
- a  in  WIDTH  minuend; captured on the accepting edge.
- b  in  WIDTH  subtrahend; captured on the accepting edge.
- bin  in  1  borrow-in; captured on the accepting edge.
- ready  out  1  high in IDLE only.
- busy  out  1  high in SHIFT only.
- done  out  1  one-cycle pulse; result valid.
- diff  out  WIDTH  result a − b − bin mod 2^WIDTH.
- bout  out  1  unsigned borrow-out: 1 when a < b + bin.
- ovf  out  1  two's-complement overflow of the signed subtraction.

## Operation

The FSM has three states: IDLE, SHIFT and DONE.
- **IDLE:** ready=1. When start=1 at an edge, the block does the following, then moves to SHIFT:
  - loads a and b into the operand shift registers;
  - loads bin into the borrow register;
  - clears the bit counter to 0;
  - latches a[WIDTH-1] and b[WIDTH-1] for overflow.
- **SHIFT:** each edge does the following:
  - applies the full-subtractor to a_sh[0], b_sh[0] and the borrow register;
  - shifts the difference bit into the work register from the MSB end;
  - stores the new borrow;
  - shifts the operands right by one;
  - increments the counter.
  - After the edge that processes bit WIDTH-1, the FSM moves to DONE.
- **DONE:** on the edge entering DONE, the block updates its output registers:
  - diff is loaded from the work register;
  - bout is loaded from the final borrow;
  - ovf = (a_msb ≠ b_msb) & (diff_msb ≠ a_msb).
  - done=1 for exactly this one cycle. The next edge returns the FSM to IDLE unconditionally.
- **Full-subtractor equations:**
  - d = x ^ y ^ bi
  - bo = (~x & y) | (~(x ^ y) & bi)
- diff, bout and ovf change only on entry to DONE. They hold their value through later IDLE and SHIFT cycles until the next DONE.
- start is ignored outside IDLE and does not queue. The a, b and bin inputs may change freely after the accepting edge.
- **Reset:** reset takes effect immediately, including mid-operation; the in-flight result is discarded.
  - state=IDLE, ready=1, busy=0, done=0;
  - diff=0, bout=0, ovf=0;
  - all internal registers cleared.

## Timing

- Edge E0 accepts start. Edges E1..E_WIDTH process bits 0..WIDTH-1.
- After E_WIDTH: done=1 and the results are valid. The FSM returns to IDLE after E_WIDTH+1.
- Latency from the accepting edge to done is WIDTH cycles. Throughput is one operation per WIDTH+2 cycles.
- ready=0 from E0 through the DONE cycle. The earliest next accept is the edge after IDLE is re-entered.
- All outputs are registered or decoded directly from state; there is no combinational path from input to output.
- Counter width is $clog2(WIDTH+1).

## Structure

- **Package serial_arith_pkg:**
  - state enum {IDLE, SHIFT, DONE};
  - a function returning the counter width.
  - Later serial adder and comparator blocks reuse this package.
- **Sub-module full_subtractor:** combinational; ports x, y, bi, d, bo. The top level instantiates exactly one.
- The top level holds the FSM, counter, shift registers, borrow register and output registers.

## Test plan

All scenarios use WIDTH=8.
- Reset, then release:
  - diff=0x00, bout=0, ovf=0, ready=1, busy=0, done=0.
- a=0x35, b=0x12, bin=0:
  - done exactly 8 cycles after the accept edge;
  - diff=0x23, bout=0, ovf=0;
  - busy high for 8 cycles.
- a=0x00, b=0x01, bin=0:
  - diff=0xFF, bout=1, ovf=0.
- a=0x80, b=0x01, bin=0:
  - diff=0x7F, bout=0, ovf=1.
- a=0x10, b=0x0F, bin=1, with start pulsed again at bit 3 using a=0xFF:
  - the second start is ignored;
  - diff=0x00, bout=0, ovf=0;
  - diff holds 0x00 until the next DONE.
- Reset mid-operation, asserted asynchronously during SHIFT at bit 4 of a=0x35, b=0x12:
  - outputs clear immediately and ready=1;
  - a following a=0x05, b=0x07 yields diff=0xFE, bout=1.
